// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: instruction fetch PC generator feeding a DEPTH-entry {PC, instruction} queue.
// Optional macro FETCH_BYPASS_EN enables same-cycle bypass of the empty queue.
module fetch_queue_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_address,
  input  logic [31:0] i_imem_instruction,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instr_pc,
  output logic [31:0] o_pc_plus4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc_q  [DEPTH];
  logic [31:0]   r_ins_q [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_head_valid, w_bypass, w_pop, w_qpop, w_adv, w_enq;
  logic [31:0]   w_redirect_pc;
  assign w_head_valid  = r_count != '0;
  assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_BYPASS_EN
  assign w_bypass      = !w_head_valid && !i_redirect && !i_rst;
  assign o_instruction = w_head_valid ? r_ins_q[r_rd_ptr] : w_bypass ? i_imem_instruction : '0;
  assign o_instr_pc    = w_head_valid ? r_pc_q[r_rd_ptr] : w_bypass ? r_fetch_pc : '0;
`else
  assign w_bypass      = 1'b0;
  assign o_instruction = w_head_valid ? r_ins_q[r_rd_ptr] : '0;
  assign o_instr_pc    = w_head_valid ? r_pc_q[r_rd_ptr] : '0;
`endif
  assign o_instr_valid  = w_head_valid | w_bypass;
  assign o_pc_plus4     = o_instr_pc + 32'd4;
  assign o_imem_address = r_fetch_pc;
  assign w_pop          = o_instr_valid & i_instr_ready;
  assign w_qpop         = w_pop & w_head_valid;
  assign w_adv          = !i_rst & !i_redirect & ((r_count < CW'(DEPTH)) | w_pop);
  // a bypassed word that decode takes this cycle never enters the queue
  assign w_enq          = w_adv & !(w_bypass & i_instr_ready);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_adv ? r_fetch_pc + 32'd4 : r_fetch_pc;
      r_wr_ptr   <= w_enq ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr   <= w_qpop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count    <= r_count + CW'(w_enq) - CW'(w_qpop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_pc_q[r_wr_ptr]  <= r_fetch_pc;
      r_ins_q[r_wr_ptr] <= i_imem_instruction;
    end
  end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: directed scoreboard bench; memory word at address A holds A.
module tb_fetch_queue_ctrl;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, redirect, ready, valid;
  logic [31:0] imem_address, imem_instruction, redirect_pc, instruction, instr_pc, pc_plus4;
  logic [31:0] sb[$];
  logic [31:0] head_pc, head_ins;
  int          n_asserts = 0, n_fail = 0, pops = 0;
  always #5 clk = ~clk;
  assign imem_instruction = imem_address;
  fetch_queue_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_address(imem_address), .i_imem_instruction(imem_instruction),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_instr_valid(valid), .i_instr_ready(ready),
    .o_instruction(instruction), .o_instr_pc(instr_pc), .o_pc_plus4(pc_plus4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic restart(input logic [31:0] start);
    sb.delete();
    for (int k = 0; k < 32; k++) sb.push_back(start + 32'(4 * k));
  endtask
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    if (valid && ready) begin
      if (sb.size() == 0) begin
        n_asserts++;
        n_fail++;
        $error("FAIL sb_empty: observed handshake pc %h expected none", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("hs_pc", instr_pc, e);
        chk("hs_instr", instruction, e);
        chk("hs_pc_plus4", pc_plus4, e + 32'd4);
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; redirect = 1'b0; ready = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_addr", imem_address, RESET_PC);
    restart(RESET_PC);
    rst = 1'b0; ready = 1'b1;
    #1 chk("latency_first", {31'b0, valid}, {31'b0, BYP});
    cyc();
    chk("latency_second", {31'b0, valid}, 32'd1);
    for (int k = 0; k < 8; k++) cyc();
    rst = 1'b1; ready = 1'b0;
    cyc();
    restart(RESET_PC);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("full_addr", imem_address, RESET_PC + 32'(4 * DEPTH));
    chk("full_valid", {31'b0, valid}, 32'd1);
    chk("full_head_pc", instr_pc, RESET_PC);
    head_pc = instr_pc; head_ins = instruction;
    cyc();
    chk("stall_pc_stable", instr_pc, head_pc);
    chk("stall_instr_stable", instruction, head_ins);
    chk("stall_addr_hold", imem_address, RESET_PC + 32'(4 * DEPTH));
    ready = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    redirect = 1'b1; redirect_pc = 32'h00000103;
    cyc();
    restart(32'h00000100);
    redirect = 1'b0;
    #1 chk("redir_addr", imem_address, 32'h00000100);
    chk("redir_valid", {31'b0, valid}, {31'b0, BYP});
    ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000040;
    cyc();
    chk("rst_redir_addr", imem_address, RESET_PC);
    chk("rst_redir_valid", {31'b0, valid}, 32'd0);
    restart(RESET_PC);
    rst = 1'b0; redirect = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    cyc();
    restart(32'hFFFFFFFC);
    redirect = 1'b0;
    chk("wrap_addr", imem_address, 32'hFFFFFFFC);
    cyc();
    chk("wrap_addr_next", imem_address, 32'h00000000);
    for (int k = 0; k < 4; k++) cyc();
    chk("pop_count_min", {31'b0, pops >= 20}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue_ctrl.md
FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2, queue entries; legal values 2, 4, 8.
REQ-003 Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 ImemAddress  output  32  address driven to the instruction memory, equal to FetchPC.
REQ-006 ImemInstruction  input  32  combinational read data returned for ImemAddress in the same cycle.
REQ-007 Redirect  input  1  taken branch/jump; flush and restart fetch.
REQ-008 RedirectPC  input  32  restart address, sampled when Redirect=1.
REQ-009 InstrValid  output  1  head instruction available to decode.
REQ-010 InstrReady  input  1  decode accepts head instruction.
REQ-011 Instruction  output  32  head instruction word.
REQ-012 InstrPC  output  32  address of head instruction.
REQ-013 PCPlus4  output  32  InstrPC + 4, modulo 2^32.

Function
REQ-014 Internal FetchPC register SHALL always have bits [1:0] = 2'b00; RedirectPC[1:0] SHALL be ignored and forced to zero.
REQ-015 Queue SHALL hold up to DEPTH {PC, instruction} pairs in FIFO order with a count register of width log2(DEPTH)+1.
REQ-016 Pop SHALL occur on a cycle where InstrValid=1 and InstrReady=1.
REQ-017 Push SHALL occur on a cycle where Redirect=0 and (count < DEPTH or pop occurs), writing {FetchPC, ImemInstruction}, and FetchPC SHALL advance by 4.
REQ-018 When full with no pop, FetchPC SHALL hold and no entry SHALL be written.
REQ-019 Simultaneous push and pop SHALL leave count unchanged.
REQ-020 FetchPC increment SHALL wrap 32'hFFFFFFFC to 32'h00000000.
REQ-021 Redirect=1 SHALL, next cycle, empty the queue (count=0), set FetchPC={RedirectPC[31:2],2'b00}, and take priority over push; a pop in the Redirect cycle is still a completed handshake.
REQ-022 InstrValid SHALL be 1 exactly when count > 0 (except REQ-030); Instruction/InstrPC SHALL show the head entry, and SHALL be 0 when InstrValid=0.
REQ-023 Latency without bypass: instruction at FetchPC appears on InstrValid one cycle after it is pushed; after reset or Redirect the first InstrValid is 2 cycles later.
REQ-024 Head outputs SHALL be stable while InstrValid=1 and InstrReady=0.
REQ-025 Back-to-back pops with InstrReady held high SHALL sustain one instruction per cycle once the queue is non-empty.

Reset
REQ-026 Rst=1 at a rising edge SHALL set FetchPC=RESET_PC, count=0, read/write pointers=0, InstrValid=0, Instruction=0, InstrPC=0, PCPlus4=4.
REQ-027 Rst SHALL take priority over Redirect, push and pop in the same cycle; reset mid-operation discards all queued entries.
REQ-028 No push SHALL occur in a cycle where Rst=1.

Configuration
REQ-029 Macro FETCH_BYPASS_EN selects same-cycle bypass of the empty queue.
REQ-030 With FETCH_BYPASS_EN defined: when count=0, Redirect=0 and Rst=0, InstrValid SHALL be 1 with Instruction=ImemInstruction, InstrPC=FetchPC; if InstrReady=1 the word SHALL be consumed directly (FetchPC += 4, nothing enqueued); otherwise it is pushed normally.
REQ-031 Without FETCH_BYPASS_EN: no combinational path from ImemInstruction to Instruction; all outputs come from queue registers.

Verification
REQ-032 Rst for 1 cycle, memory[i]=i*4, InstrReady=1 -> InstrPC sequence 0,4,8,... with Instruction equal to InstrPC, one per cycle from cycle 2 (cycle 1 with bypass).
REQ-033 InstrReady=0 for 5 cycles -> count reaches DEPTH, FetchPC stops at RESET_PC+4*DEPTH, head stays at PC 0; release -> PCs 0,4,8 in order, none lost or duplicated.
REQ-034 Redirect=1, RedirectPC=32'h00000103 while queue full -> next cycle count=0, FetchPC=32'h00000100, next valid InstrPC=32'h00000100.
REQ-035 Redirect and Rst asserted together with RedirectPC=32'h40 -> FetchPC=RESET_PC, InstrValid=0.
REQ-036 RedirectPC=32'hFFFFFFFC, InstrReady=1 -> InstrPC 32'hFFFFFFFC then 32'h00000000, PCPlus4 at wrap = 32'h00000000.
REQ-037 Run REQ-032..REQ-036 with and without FETCH_BYPASS_EN; instruction/PC order identical, only latency differs.
